// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: multi-line CP0 interrupt controller with vectored handlers.
// Edge-detected lines feed PENDING; the lowest unmasked pending index is taken
// when the pipeline allows, saving EPC and jumping to EHBR + ID*VEC_STRIDE.
// Optional feature macro: CP0_TIMER_EN (COUNT/COMPARE timer on line N_IRQ).
module cp0_irq_ctrl #(
    parameter int unsigned N_IRQ      = 4,
    parameter logic [31:0] VEC_STRIDE = 32'h20,
    parameter logic [31:0] EHBR_RST   = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr
);

`ifdef CP0_TIMER_EN
    localparam int unsigned NL = N_IRQ + 1;
`else
    localparam int unsigned NL = N_IRQ;
`endif
    localparam int unsigned ID_W = 4;

    localparam logic [1:0] OP_MFC0 = 2'b01;
    localparam logic [1:0] OP_MTC0 = 2'b10;
    localparam logic [1:0] OP_ERET = 2'b11;

    localparam logic [4:0] A_STATUS  = 5'd0;
    localparam logic [4:0] A_CAUSE   = 5'd1;
    localparam logic [4:0] A_EPC     = 5'd2;
    localparam logic [4:0] A_EHBR    = 5'd3;
`ifdef CP0_TIMER_EN
    localparam logic [4:0] A_COUNT   = 5'd4;
    localparam logic [4:0] A_COMPARE = 5'd5;
`endif

    typedef enum logic {S_IDLE, S_IN_HANDLER} state_t;

    state_t            state_q, state_d;
    logic              ie_q;
    logic [NL-1:0]     mask_q;
    logic [NL-1:0]     pending_q, pending_d;
    logic [2:0]        cause_id_q;
    logic [31:0]       epc_q;
    logic [31:0]       ehbr_q;
    logic [N_IRQ-1:0]  irq_prev_q;

    logic              is_eret;
    logic              take;
    logic              wr_en;
    logic [NL-1:0]     pend_en;
    logic [NL-1:0]     set_v;
    logic [NL-1:0]     clr_v;
    logic [ID_W-1:0]   sel_id;
    logic [31:0]       vec_addr;
    logic [31:0]       rd_mux;
    logic              unused_bits;

`ifdef CP0_TIMER_EN
    logic [31:0]       count_q;
    logic [31:0]       compare_q;
    logic              timer_hit;
    assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);
`endif

    assign unused_bits = ^{data_w[31:8+NL], data_w[7:1]};

    assign is_eret  = (oper == OP_ERET);
    assign pend_en  = pending_q & mask_q;
    assign take     = !rst && (state_q == S_IDLE) && ie_q && ir_en && (|pend_en) && !is_eret;
    assign wr_en    = (oper == OP_MTC0) && !take;
    assign vec_addr = ehbr_q + (32'(sel_id) * VEC_STRIDE);

    // Priority encoder: lowest set index of the enabled pending lines
    always_comb begin
        sel_id = '0;
        for (int i = int'(NL) - 1; i >= 0; i--) begin
            if (pend_en[i]) sel_id = ID_W'(i);
        end
    end

    // Pending set/clear vectors; a new edge wins over take-clear and W1C
    always_comb begin
        clr_v = '0;
        for (int i = 0; i < int'(NL); i++) begin
            clr_v[i] = take && (sel_id == ID_W'(i));
        end
        if (wr_en && (addr_w == A_CAUSE)) clr_v = clr_v | data_w[8 +: NL];
`ifdef CP0_TIMER_EN
        if (wr_en && (addr_w == A_COMPARE)) clr_v[N_IRQ] = 1'b1;
        set_v = {timer_hit, irq_in & ~irq_prev_q};
`else
        set_v = irq_in & ~irq_prev_q;
`endif
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    // MFC0 read mux; zero when not reading
    always_comb begin
        rd_mux = '0;
        case (addr_r)
            A_STATUS: begin
                rd_mux[0]       = ie_q;
                rd_mux[8 +: NL] = mask_q;
            end
            A_CAUSE: begin
                rd_mux[8 +: NL] = pending_q;
                rd_mux[4:2]     = cause_id_q;
            end
            A_EPC:     rd_mux = epc_q;
            A_EHBR:    rd_mux = ehbr_q;
`ifdef CP0_TIMER_EN
            A_COUNT:   rd_mux = count_q;
            A_COMPARE: rd_mux = compare_q;
`endif
            default:   rd_mux = '0;
        endcase
        data_r = (oper == OP_MFC0) ? rd_mux : 32'd0;
    end

    // Next state and jump strobe; ERET beats take
    always_comb begin
        state_d   = state_q;
        jump_en   = 1'b0;
        jump_addr = '0;
        if (!rst && is_eret) begin
            jump_en   = 1'b1;
            jump_addr = epc_q;
            state_d   = S_IDLE;
        end else if (take) begin
            jump_en   = 1'b1;
            jump_addr = vec_addr;
            state_d   = S_IN_HANDLER;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // CP0 register file, edge detector and take side effects
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q       <= 1'b0;
            mask_q     <= '0;
            pending_q  <= '0;
            cause_id_q <= '0;
            epc_q      <= '0;
            ehbr_q     <= EHBR_RST;
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            if (take) begin
                epc_q      <= ret_addr;
                cause_id_q <= sel_id[2:0];
            end else if (wr_en && (addr_w == A_EPC)) begin
                epc_q <= data_w;
            end
            if (wr_en && (addr_w == A_STATUS)) begin
                ie_q   <= data_w[0];
                mask_q <= data_w[8 +: NL];
            end
            if (wr_en && (addr_w == A_EHBR)) ehbr_q <= data_w;
        end
    end

`ifdef CP0_TIMER_EN
    // Free-running COUNT and COMPARE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            if (wr_en && (addr_w == A_COUNT)) count_q <= data_w;
            else                              count_q <= count_q + 32'd1;
            if (wr_en && (addr_w == A_COMPARE)) compare_q <= data_w;
        end
    end
`endif

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: stimulus queues expected MFC0 data and
// expected jumps (target + cycle); a negedge monitor pops and compares.
module tb_cp0_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [3:0]  irq_in;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } jexp_t;

    jexp_t       jq[$];
    logic [31:0] rq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    cp0_irq_ctrl #(
        .N_IRQ(4),
        .VEC_STRIDE(32'h20),
        .EHBR_RST(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .oper(oper),
        .addr_r(addr_r),
        .data_r(data_r),
        .addr_w(addr_w),
        .data_w(data_w),
        .ir_en(ir_en),
        .irq_in(irq_in),
        .ret_addr(ret_addr),
        .jump_en(jump_en),
        .jump_addr(jump_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares DUT outputs against queued expectations
    always @(negedge clk) begin
        logic [31:0] e;
        jexp_t       j;
        if (!rst) begin
            if (oper == 2'b01) begin
                tests++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL mfc0_unexpected cyc=%0d addr_r=%0d got=%h required=no_read", cyc, addr_r, data_r);
                end else begin
                    e = rq.pop_front();
                    if (data_r !== e) begin
                        fails++;
                        $display("FAIL mfc0_read cyc=%0d addr_r=%0d got=%h required=%h", cyc, addr_r, data_r, e);
                    end
                end
            end else begin
                tests++;
                if (data_r !== 32'd0) begin
                    fails++;
                    $display("FAIL data_r_idle cyc=%0d got=%h required=0", cyc, data_r);
                end
            end
        end
        if (jump_en) begin
            tests++;
            if (jq.size() == 0) begin
                fails++;
                $display("FAIL jump_unexpected cyc=%0d got=%h required=no_jump", cyc, jump_addr);
            end else begin
                j = jq.pop_front();
                if (jump_addr !== j.addr || cyc != j.cyc) begin
                    fails++;
                    $display("FAIL jump cyc=%0d got=%h required=%h at cyc %0d", cyc, jump_addr, j.addr, j.cyc);
                end
            end
        end else begin
            tests++;
            if (jump_addr !== 32'd0) begin
                fails++;
                $display("FAIL jump_addr_idle cyc=%0d got=%h required=0", cyc, jump_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        oper   = 2'b01;
        addr_r = a;
        rq.push_back(e);
        tick();
        oper   = 2'b00;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        oper   = 2'b10;
        addr_w = a;
        data_w = d;
        tick();
        oper   = 2'b00;
    endtask

    task automatic eret();
        oper = 2'b11;
        tick();
        oper = 2'b00;
    endtask

    task automatic expect_jump(input logic [31:0] a, input int dc);
        jexp_t j;
        j.addr = a;
        j.cyc  = cyc + dc;
        jq.push_back(j);
    endtask

    initial begin
        rst = 1'b1; oper = 2'b00; addr_r = '0; addr_w = '0; data_w = '0;
        ir_en = 1'b1; irq_in = 4'b0000; ret_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd(5'd0, 32'h0); rd(5'd1, 32'h0); rd(5'd2, 32'h0); rd(5'd3, 32'h0);

        // Basic take of line 2
        wr(5'd0, 32'h0000_0F01);
        wr(5'd3, 32'h100);
        rd(5'd0, 32'h0000_0F01);
        rd(5'd3, 32'h100);
        ret_addr = 32'h40; irq_in = 4'b0100;
        expect_jump(32'h140, 1);
        tick(); tick();
        rd(5'd2, 32'h40);
        rd(5'd1, 32'h08);
        expect_jump(32'h40, 0);
        eret();

        // Lines 3 and 1 together: 1 first, 3 right after ERET
        irq_in = 4'b1010; ret_addr = 32'h80;
        expect_jump(32'h120, 1);
        tick(); tick();
        rd(5'd1, 32'h804);
        ret_addr = 32'hC0;
        expect_jump(32'h80, 0);
        expect_jump(32'h160, 1);
        eret(); tick();
        rd(5'd2, 32'hC0);
        rd(5'd1, 32'h0C);
        expect_jump(32'hC0, 0);
        eret();

        // Edge while in handler waits for ERET
        irq_in = 4'b1011; ret_addr = 32'h200;
        expect_jump(32'h100, 1);
        tick(); tick();
        irq_in = 4'b1111;
        tick();
        repeat (3) tick();
        ret_addr = 32'h300;
        expect_jump(32'h200, 0);
        expect_jump(32'h140, 1);
        eret(); tick();
        expect_jump(32'h300, 0);
        eret();

        // Mask, IE and W1C gating
        wr(5'd0, 32'h0000_0E01);
        irq_in = 4'b1110; tick();
        irq_in = 4'b1111; tick();
        repeat (3) tick();
        rd(5'd1, 32'h108);
        wr(5'd0, 32'h0000_0F00);
        repeat (2) tick();
        rd(5'd0, 32'h0000_0F00);
        wr(5'd1, 32'h100);
        rd(5'd1, 32'h08);
        repeat (2) tick();
        rd(5'd1, 32'h08);
        irq_in = 4'b0111; tick();
        irq_in = 4'b1111; tick();
        ret_addr = 32'h700;
        expect_jump(32'h160, 1);
        wr(5'd0, 32'h0000_0F01);
        tick();
        rd(5'd2, 32'h700);
        expect_jump(32'h700, 0);
        eret();
        rd(5'd4, 32'h0);

        // ERET beats a pending take, EPC unchanged
        ir_en = 1'b0;
        irq_in = 4'b1101; tick();
        irq_in = 4'b1111; tick();
        ir_en = 1'b1; ret_addr = 32'h500;
        expect_jump(32'h700, 0);
        eret();
        ir_en = 1'b0;
        rd(5'd2, 32'h700);
        ir_en = 1'b1; ret_addr = 32'h600;
        expect_jump(32'h120, 0);
        tick();
        rd(5'd2, 32'h600);
        rd(5'd1, 32'h04);

        // Reset mid-handler clears pending, no jump
        irq_in = 4'b1011; tick();
        irq_in = 4'b1111; tick();
        rd(5'd1, 32'h404);
        rst = 1'b1; irq_in = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        rd(5'd1, 32'h0); rd(5'd0, 32'h0); rd(5'd2, 32'h0); rd(5'd3, 32'h0);
        repeat (2) tick();

        tests++;
        if (jq.size() != 0) begin
            fails++;
            $display("FAIL jump_missing got=%0d outstanding required=0", jq.size());
        end
        tests++;
        if (rq.size() != 0) begin
            fails++;
            $display("FAIL read_missing got=%0d outstanding required=0", rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
